// File: rtl/bus_slave_mem.sv
// Memory-backed bus responder: latches one transfer, stalls WAIT_CYCLES cycles,
// then pulses ready with read data or an error response.
module bus_slave_mem #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       DEPTH_LOG2  = 8,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trans,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int unsigned DEPTH   = 2 ** DEPTH_LOG2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TAG_LSB = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Transfer being completed: live bus inputs on a zero-wait accept, latched copy otherwise
  logic                  cur_write;
  logic [ADDR_W-1:0]     cur_addr;
  logic [DATA_W-1:0]     cur_wdata;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic                  cur_legal;
  logic                  resp_go;
  logic                  mem_we;

  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_write = write;
      cur_addr  = addr;
      cur_wdata = wdata;
    end else begin
      cur_write = write_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    cur_idx   = cur_addr[DEPTH_LOG2+1:2];
    cur_legal = (cur_addr[1:0] == 2'b00) &&
                (cur_addr[ADDR_W-1:TAG_LSB] == BASE_ADDR[ADDR_W-1:TAG_LSB]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    busy_d  = busy_q;
    resp_go = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (trans == 1'b1) begin
          write_d = write;
          addr_d  = addr;
          wdata_d = wdata;
          busy_d  = 1'b1;
          if (WAIT_CYCLES == 0) begin
            resp_go = 1'b1;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          resp_go = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Memory commit and response data are decided on the edge that enters RESP
    if (resp_go) begin
      state_d = ST_RESP;
      ready_d = 1'b1;
      busy_d  = 1'b1;
      if (!cur_legal) begin
        err_d   = 1'b1;
        rdata_d = ERR_DATA;
      end else if (cur_write) begin
        mem_we  = 1'b1;
      end else begin
        rdata_d = mem[cur_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Array is not reset; a reset on the commit edge drops the write
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: one instance with two wait cycles, one with none,
// checked against an array-based model of the memory window.
module tb_bus_slave_mem;

  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_v   [2];
  logic        trans_v [2];
  logic        write_v [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  wire  [31:0] rdata_w [2];
  wire         ready_w [2];
  wire         err_w   [2];
  wire         busy_w  [2];

  int          wc [2];
  logic [31:0] ref_mem [2][256];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  bus_slave_mem #(.WAIT_CYCLES(2)) u_wait2 (
    .clk(clk), .rst(rst_v[0]), .trans(trans_v[0]), .write(write_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata_w[0]),
    .ready(ready_w[0]), .err(err_w[0]), .busy(busy_w[0])
  );

  bus_slave_mem #(.WAIT_CYCLES(0)) u_wait0 (
    .clk(clk), .rst(rst_v[1]), .trans(trans_v[1]), .write(write_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata_w[1]),
    .ready(ready_w[1]), .err(err_w[1]), .busy(busy_w[1])
  );

  // Model of one access: window is 0x000..0x3FF, word aligned
  task automatic model_op(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] er, output logic ee);
    if (a[1:0] == 2'b00 && a[31:10] == 22'd0) begin
      ee = 1'b0;
      er = ref_mem[d][a[9:2]];
      if (w) ref_mem[d][a[9:2]] = wd;
    end else begin
      ee = 1'b1;
      er = ERR_WORD;
    end
  endtask

  // Present a transfer and wait for ready; keep=1 leaves trans high for back-to-back
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input bit keep, output logic [31:0] rd, output logic e,
                      output int lat, output int nb);
    trans_v[d] = 1'b1; write_v[d] = w; addr_v[d] = a; wdata_v[d] = wd;
    lat = -1; nb = 0; rd = 'x; e = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (busy_w[d]) nb++;
      if (ready_w[d]) begin
        lat = i; rd = rdata_w[d]; e = err_w[d];
        break;
      end
    end
    if (!keep) begin
      trans_v[d] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; trans_v[d] = 1'b0; write_v[d] = 1'b0; addr_v[d] = '0; wdata_v[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({ready_w[d], err_w[d], busy_w[d]} !== 3'b000 || rdata_w[d] !== 32'd0)
        $display("FAIL reset_outputs dut%0d: ready/err/busy=%b%b%b rdata=%h, required 000 and 0",
                 d, ready_w[d], err_w[d], busy_w[d], rdata_w[d]);
      else n_pass++;
    end
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;
  endtask

  // Give every word a known value so later reads never touch uninitialised storage
  task automatic fill_mem;
    logic [31:0] rd, wd, er; logic e, ee; int lat, nb;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) begin
        wd = $urandom;
        model_op(d, 1'b1, 32'(i * 4), wd, er, ee);
        xfer(d, 1'b1, 32'(i * 4), wd, 1'b0, rd, e, lat, nb);
      end
  endtask

  task automatic test_write_read;
    logic [31:0] rd, er; logic e, ee; int lat, nb;
    model_op(0, 1'b1, 32'h10, 32'hA5A5_0001, er, ee);
    xfer(0, 1'b1, 32'h10, 32'hA5A5_0001, 1'b0, rd, e, lat, nb);
    n_checks++;
    if (lat !== 3 || e !== 1'b0)
      $display("FAIL write_latency: ready after %0d edges err=%b, required 3 edges err=0", lat, e);
    else n_pass++;
    n_checks++;
    if (nb !== 3) $display("FAIL write_busy: busy seen %0d cycles, required 3", nb);
    else n_pass++;
    n_checks++;
    if (busy_w[0] !== 1'b0 || ready_w[0] !== 1'b0)
      $display("FAIL write_idle: busy=%b ready=%b, required 0 0", busy_w[0], ready_w[0]);
    else n_pass++;
    model_op(0, 1'b0, 32'h10, 32'h0, er, ee);
    xfer(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, e, lat, nb);
    n_checks++;
    if (lat !== 3 || e !== 1'b0 || rd !== 32'hA5A5_0001)
      $display("FAIL read_after_write: lat=%0d err=%b rdata=%h, required 3 0 a5a50001", lat, e, rd);
    else n_pass++;
  endtask

  task automatic test_errors;
    logic [31:0] rd, er; logic e, ee; int lat, nb;
    model_op(0, 1'b1, 32'h400, 32'h0BAD_0BAD, er, ee);
    xfer(0, 1'b1, 32'h400, 32'h0BAD_0BAD, 1'b0, rd, e, lat, nb);
    n_checks++;
    if (e !== 1'b1 || rd !== ERR_WORD || lat !== 3)
      $display("FAIL out_of_window: err=%b rdata=%h lat=%0d, required 1 deadbeef 3", e, rd, lat);
    else n_pass++;
    model_op(0, 1'b0, 32'h0, 32'h0, er, ee);
    xfer(0, 1'b0, 32'h0, 32'h0, 1'b0, rd, e, lat, nb);
    n_checks++;
    if (e !== 1'b0 || rd !== er)
      $display("FAIL word0_unchanged: err=%b rdata=%h, required 0 %h", e, rd, er);
    else n_pass++;
    xfer(0, 1'b0, 32'h13, 32'h0, 1'b0, rd, e, lat, nb);
    n_checks++;
    if (e !== 1'b1 || rd !== ERR_WORD)
      $display("FAIL misaligned: err=%b rdata=%h, required 1 deadbeef", e, rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, er, wd [3]; logic e, ee; int lat, nb;
    for (int i = 0; i < 3; i++) begin
      wd[i] = $urandom;
      model_op(1, 1'b1, 32'(i * 4), wd[i], er, ee);
      xfer(1, 1'b1, 32'(i * 4), wd[i], 1'b1, rd, e, lat, nb);
      n_checks++;
      if (lat !== (i == 0 ? 1 : 2) || e !== 1'b0)
        $display("FAIL b2b_write%0d: lat=%0d err=%b, required %0d 0", i, lat, e, i == 0 ? 1 : 2);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      model_op(1, 1'b0, 32'(i * 4), 32'h0, er, ee);
      xfer(1, 1'b0, 32'(i * 4), 32'h0, i != 2, rd, e, lat, nb);
      n_checks++;
      if (lat !== 2 || e !== 1'b0 || rd !== wd[i])
        $display("FAIL b2b_read%0d: lat=%0d err=%b rdata=%h, required 2 0 %h", i, lat, e, rd, wd[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd, er; logic e, ee; int lat, nb, seen;
    trans_v[0] = 1'b1; write_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'h1234;
    @(posedge clk); #1;
    trans_v[0] = 1'b0; rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    n_checks++;
    if (busy_w[0] !== 1'b0 || ready_w[0] !== 1'b0 || err_w[0] !== 1'b0)
      $display("FAIL abort_outputs: busy=%b ready=%b err=%b, required 0 0 0",
               busy_w[0], ready_w[0], err_w[0]);
    else n_pass++;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready_w[0]) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL abort_no_ready: %0d ready pulses, required 0", seen);
    else n_pass++;
    model_op(0, 1'b0, 32'h20, 32'h0, er, ee);
    xfer(0, 1'b0, 32'h20, 32'h0, 1'b0, rd, e, lat, nb);
    n_checks++;
    if (rd !== er || e !== 1'b0)
      $display("FAIL abort_read: rdata=%h err=%b, required %h 0", rd, e, er);
    else n_pass++;
  endtask

  task automatic test_unknown_trans;
    int seen = 0;
    trans_v[1] = 1'bx; write_v[1] = 1'b1; addr_v[1] = 32'h4;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy_w[1] !== 1'b0 || ready_w[1] !== 1'b0) seen++;
    end
    trans_v[1] = 1'b0;
    n_checks++;
    if (seen !== 0) $display("FAIL unknown_trans: %0d cycles with busy/ready, required 0", seen);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rd, er; logic w, e, ee; int lat, nb, kind, exp_lat; bit keep, prev_keep;
    for (int d = 0; d < 2; d++) begin
      prev_keep = 1'b0;
      for (int n = 0; n < 40; n++) begin
        kind = $urandom_range(0, 7);
        w    = 1'($urandom_range(0, 1));
        wd   = $urandom;
        keep = (n != 39) && ($urandom_range(0, 2) == 0);
        if (kind == 0)      a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0400;
        else if (kind == 1) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else                a = 32'($urandom_range(0, 15) * 4);
        model_op(d, w, a, wd, er, ee);
        exp_lat = wc[d] + (prev_keep ? 2 : 1);
        xfer(d, w, a, wd, keep, rd, e, lat, nb);
        n_checks++;
        if (lat !== exp_lat || e !== ee || ((!w || ee) && rd !== er))
          $display("FAIL random dut%0d op%0d %s %h: lat=%0d err=%b rdata=%h, required %0d %b %h",
                   d, n, w ? "wr" : "rd", a, lat, e, rd, exp_lat, ee, er);
        else n_pass++;
        prev_keep = keep;
      end
    end
  endtask

  initial begin
    wc[0] = 2; wc[1] = 0;
    test_reset;
    fill_mem;
    test_write_read;
    test_errors;
    test_back_to_back;
    test_reset_abort;
    test_unknown_trans;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
